// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for the sequential multi-word adder.
// W is the full operand width (slice width times slice count).
interface multiword_add_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-precision adder that streams BIT_WIDTH slices, LSB first, through one
// full_adder with the carry registered between slices.

module full_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module multiword_add_seq #(
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_SLICES = 4
) (
  input logic               clk,
  input logic               rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int W     = BIT_WIDTH * NUM_SLICES;
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [W-1:0]         res_reg;
  logic [W-1:0]         sum_reg;
  logic                 carry_reg;
  logic                 cout_reg;
  logic                 valid_reg;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] fa_sum;
  logic                 fa_cout;
  logic [W+BIT_WIDTH-1:0] res_cat;
  logic                 last_slice;

  full_adder #(.WIDTH(BIT_WIDTH)) u_fa (
    .a    (a_reg[BIT_WIDTH-1:0]),
    .b    (b_reg[BIT_WIDTH-1:0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_slice = (cnt == LAST);
  // New slice enters at the top; after NUM_SLICES shifts the word is in order.
  assign res_cat    = {fa_sum, res_reg};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_slice)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
            cnt       <= '0;
          end
        end
        RUN: begin
          carry_reg <= fa_cout;
          a_reg     <= a_reg >> BIT_WIDTH;
          b_reg     <= b_reg >> BIT_WIDTH;
          res_reg   <= res_cat[W+BIT_WIDTH-1:BIT_WIDTH];
          if (last_slice) begin
            cnt       <= '0;
            sum_reg   <= res_cat[W+BIT_WIDTH-1:BIT_WIDTH];
            cout_reg  <= fa_cout;
            valid_reg <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: default 4-slice build against a cycle-level
// edge-count model, plus 1-slice and 8-slice builds against queue scoreboards.
`timescale 1ns/1ps
module tb_multiword_add_seq;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_aux;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multiword_add_seq_if #(.W(16)) bus  ();
  multiword_add_seq_if #(.W(4))  bus1 ();
  multiword_add_seq_if #(.W(32)) bus8 ();

  multiword_add_seq #(.BIT_WIDTH(4), .NUM_SLICES(4)) dut  (.clk(clk), .rst_n(rst_n),   .bus(bus));
  multiword_add_seq #(.BIT_WIDTH(4), .NUM_SLICES(1)) dut1 (.clk(clk), .rst_n(rst_aux), .bus(bus1));
  multiword_add_seq #(.BIT_WIDTH(4), .NUM_SLICES(8)) dut8 (.clk(clk), .rst_n(rst_aux), .bus(bus8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Default-build model: an op accepted on edge E is owed at edge E+NS and
  // stays owed until it is taken; the visible result is the last one owed.
  bit          m_busy;
  bit          m_vld;
  int          m_acc;
  logic [16:0] m_res;
  logic [16:0] m_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_vld  = 0;
      m_last = '0;
    end
    check("in_ready",  bus.in_ready,  !m_busy);
    check("out_valid", bus.out_valid, m_vld);
    check("out_sum",   bus.out_sum,   m_last[15:0]);
    check("out_cout",  bus.out_cout,  m_last[16]);
    if (rst_n) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1;
          m_acc  = cyc + 1;
          m_res  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {16'd0, bus.in_cin};
        end
      end else if (m_vld && bus.out_ready) begin
        m_busy = 0;
        m_vld  = 0;
      end
      if (m_busy && !m_vld && (cyc + 1 - m_acc) >= NS) begin
        m_vld  = 1;
        m_last = m_res;
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int stall, input bit pulse,
                        output logic [15:0] s, output logic c, output int lat);
    int n = 0;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail_now("accept");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.in_cin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) fail_now("result");
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin bus.in_valid = 1'b1; bus.in_a = 16'($urandom); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    s = bus.out_sum;
    c = bus.out_cout;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle after release", bus.in_ready, 1'b1);
  endtask

  // 1-slice and 8-slice scoreboards
  logic [4:0]  q1[$];
  logic [32:0] q8[$];
  int acc1, acc8, n1 = 0, n8 = 0;
  bit pv1, pv8, d1 = 0, d8 = 0;

  always @(negedge clk) begin
    if (rst_aux) begin
      if (bus1.out_valid && !pv1) check("ns1 latency", cyc - acc1, 1);
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) fail_now("ns1 unexpected result");
        else check("ns1 result", {bus1.out_cout, bus1.out_sum}, q1.pop_front());
        n1++;
      end
      if (bus1.in_valid && bus1.in_ready) begin
        q1.push_back({1'b0, bus1.in_a} + {1'b0, bus1.in_b} + {4'd0, bus1.in_cin});
        acc1 = cyc + 1;
      end
      if (bus8.out_valid && !pv8) check("ns8 latency", cyc - acc8, 8);
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) fail_now("ns8 unexpected result");
        else check("ns8 result", {bus8.out_cout, bus8.out_sum}, q8.pop_front());
        n8++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back({1'b0, bus8.in_a} + {1'b0, bus8.in_b} + {32'd0, bus8.in_cin});
        acc8 = cyc + 1;
      end
    end
    pv1 = bus1.out_valid;
    pv8 = bus8.out_valid;
  end

  initial begin : drv1
    int n;
    bit done;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
    wait (rst_aux === 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 200; k++) begin
      if (k == 0) begin bus1.in_a = 4'hF; bus1.in_b = 4'hF; bus1.in_cin = 1'b1; end
      else begin bus1.in_a = 4'($urandom); bus1.in_b = 4'($urandom); bus1.in_cin = 1'($urandom); end
      bus1.in_valid = 1'b1;
      n = 0;
      while (!bus1.in_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      n = 0; done = 0;
      while (!done && n < 100) begin
        bus1.out_ready = (k == 0) ? 1'b1 : 1'($urandom);
        done = bus1.out_valid && bus1.out_ready;
        if (done && k == 0) begin
          check("ns1 F+F+1 sum",  bus1.out_sum,  4'hF);
          check("ns1 F+F+1 cout", bus1.out_cout, 1'b1);
        end
        @(posedge clk); #1;
        n++;
      end
      bus1.out_ready = 1'b0;
      if (!done) fail_now("ns1 handshake");
    end
    d1 = 1;
  end

  initial begin : drv8
    int n;
    bit done;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.in_a = '0; bus8.in_b = '0; bus8.in_cin = 1'b0;
    wait (rst_aux === 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) begin
      bus8.in_a = $urandom; bus8.in_b = $urandom; bus8.in_cin = 1'($urandom);
      bus8.in_valid = 1'b1;
      n = 0;
      while (!bus8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n = 0; done = 0;
      while (!done && n < 100) begin
        bus8.out_ready = 1'($urandom);
        done = bus8.out_valid && bus8.out_ready;
        @(posedge clk); #1;
        n++;
      end
      bus8.out_ready = 1'b0;
      if (!done) fail_now("ns8 handshake");
    end
    d8 = 1;
  end

  initial begin : main
    logic [15:0] s, a, b;
    logic        c, ci;
    int          lat, g;
    rst_n = 1'b0; rst_aux = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    #1;
    check("reset in_ready",  bus.in_ready,  1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; rst_aux = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0000, 16'h0000, 1'b0, 0, 0, s, c, lat);
    check("zero sum", s, 16'h0000); check("zero cout", c, 1'b0); check("zero latency", lat, 4);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, s, c, lat);
    check("ffff sum", s, 16'hFFFF); check("ffff cout", c, 1'b1);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 0, s, c, lat);
    check("00ff sum", s, 16'h0100); check("00ff cout", c, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0, s, c, lat);
    check("7fff sum", s, 16'h8000); check("7fff cout", c, 1'b0);

    // Held result under backpressure with junk in_valid pulses
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 5, 1, s, c, lat);
    check("stall sum", s, 16'h0000); check("stall cout", c, 1'b1);

    // Abort two slices into an operation
    bus.in_a = 16'h9999; bus.in_b = 16'h8888; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort in_ready",  bus.in_ready,  1'b1);
    check("abort out_sum",   bus.out_sum,   16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    run_op(16'h1234, 16'h4321, 1'b0, 0, 0, s, c, lat);
    check("post-abort sum", s, 16'h5555); check("post-abort cout", c, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      run_op(a, b, ci, $urandom_range(0, 3), 1'($urandom), s, c, lat);
      check("random result", {c, s}, {1'b0, a} + {1'b0, b} + {16'd0, ci});
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end

    g = 0;
    while (!(d1 && d8) && g < 20000) begin @(posedge clk); g++; end
    if (!(d1 && d8)) fail_now("aux drivers");
    check("ns1 count", n1, 200);
    check("ns8 count", n8, 300);
    check("ns1 leftovers", q1.size(), 0);
    check("ns8 leftovers", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
